// File: rtl/mem_access_unit.sv
`default_nettype none
// mem_access_unit: MEM-stage load/store initiator on a word-wide memory port.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended. Revision 1.0
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [31:0]       addr,
   output logic              mem_read_control,
   output logic              write_data_control,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LD_RD   = 4'd1,
      S_LD_CAP  = 4'd2,
      S_ST_WR   = 4'd3,
      S_RMW_RD  = 4'd4,
      S_RMW_MRG = 4'd5,
      S_RMW_WR  = 4'd6,
      S_ERR     = 4'd7,
      S_RESP    = 4'd8
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-3:0]   widx_q;
   logic [1:0]          off_q;
   logic [1:0]          size_q;
   logic                signed_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;

   logic                accept;
   logic                misaligned;
   logic [7:0]          lane_b;
   logic [15:0]         lane_h;
   logic [DATA_W-1:0]   load_ext;
   logic [DATA_W-1:0]   merged;

   assign accept     = req_valid && (state_q == S_IDLE);
   assign misaligned = (req_size == 2'd3) ||
                       ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (misaligned)              state_d = S_ERR;
               else if (!req_we)            state_d = S_LD_RD;
               else if (req_size == 2'd2)   state_d = S_ST_WR;
               else                         state_d = S_RMW_RD;
            end
         end
         S_LD_RD:   state_d = S_LD_CAP;
         S_LD_CAP:  state_d = S_RESP;
         S_ST_WR:   state_d = S_RESP;
         S_RMW_RD:  state_d = S_RMW_MRG;
         S_RMW_MRG: state_d = S_RMW_WR;
         S_RMW_WR:  state_d = S_RESP;
         S_ERR:     state_d = S_IDLE;
         S_RESP:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // rdata is only valid in LD_CAP / RMW_MRG, one cycle after the read strobe
   always_comb begin
      lane_b   = rdata[{off_q, 3'b000} +: 8];
      lane_h   = rdata[{off_q[1], 4'b0000} +: 16];
      load_ext = rdata;
      case (size_q)
         2'd0:    load_ext = signed_q ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
         2'd1:    load_ext = signed_q ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
         default: load_ext = rdata;
      endcase
   end

   always_comb begin
      merged = rdata;
      if (size_q == 2'd0) begin
         merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         widx_q   <= '0;
         off_q    <= 2'b00;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         if (accept) begin
            widx_q   <= req_addr[ADDR_W-1:2];
            off_q    <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
         end
         if (state_q == S_LD_CAP) begin
            rdata_q <= load_ext;
         end
         // merged word is held here so RMW_WR no longer depends on rdata
         if (state_q == S_RMW_MRG) begin
            wdata_q <= merged;
         end
      end
   end

   assign req_ready          = (state_q == S_IDLE);
   assign resp_valid         = (state_q == S_RESP) || (state_q == S_ERR);
   assign resp_err           = (state_q == S_ERR);
   assign resp_rdata         = rdata_q;
   assign addr               = 32'(widx_q);
   assign mem_read_control   = (state_q == S_LD_RD) || (state_q == S_RMW_RD);
   assign write_data_control = (state_q == S_ST_WR) || (state_q == S_RMW_WR);
   assign wdata              = (state_q == S_RMW_MRG) ? merged : wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// tb_mem_access_unit: directed and random load/store requests checked against a
// byte-addressed reference memory. Revision 1.0
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] addr;
   logic        mem_read_control;
   logic        write_data_control;
   logic [31:0] wdata;
   logic [31:0] rdata;

   int total  = 0;
   int passes = 0;
   int fails  = 0;

   logic [31:0] mem [16];
   logic [7:0]  rb  [64];

   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          ov_cnt = 0;
   logic [31:0] last_addr  = '0;
   logic [31:0] last_wdata = '0;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_we             (req_we),
      .req_size           (req_size),
      .req_signed         (req_signed),
      .req_addr           (req_addr),
      .req_wdata          (req_wdata),
      .resp_valid         (resp_valid),
      .resp_rdata         (resp_rdata),
      .resp_err           (resp_err),
      .addr               (addr),
      .mem_read_control   (mem_read_control),
      .write_data_control (write_data_control),
      .wdata              (wdata),
      .rdata              (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // word memory behind the port: one-cycle read latency, write at the edge
   always @(posedge clk) begin
      if (write_data_control) mem[addr[3:0]] <= wdata;
      if (mem_read_control)   rdata <= mem[addr[3:0]];
   end

   always @(negedge clk) begin
      if (mem_read_control) begin
         rd_cnt    <= rd_cnt + 1;
         last_addr <= addr;
      end
      if (write_data_control) begin
         wr_cnt     <= wr_cnt + 1;
         last_addr  <= addr;
         last_wdata <= wdata;
      end
      if (mem_read_control && write_data_control) ov_cnt <= ov_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input int n, input bit sg, input int ai);
      longint v;
      v = 0;
      for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(rb[ai + i]);
      if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_word(input int w);
      return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
   endfunction

   task automatic ref_store(input int n, input int ai, input logic [31:0] wd);
      for (int i = 0; i < n; i++) rb[ai + i] = wd[8*i +: 8];
   endtask

   task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
      int          n, ai, lat, rd0, wr0, exp_lat, exp_rdc, exp_wrc;
      bit          err_exp, got, ready_low;
      logic [31:0] exp_rd;
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      ai = int'(a[5:0]);
      err_exp = (sz == 2'd3) || ((ai % n) != 0);

      @(negedge clk);
      check({tag, " ready idle"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      req_valid  = 1'b0;
      req_we     = 1'($urandom());
      req_size   = 2'($urandom());
      req_signed = 1'($urandom());
      req_addr   = $urandom();
      req_wdata  = $urandom();

      lat = 0; got = 1'b0; ready_low = 1'b1;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (req_ready)  ready_low = 1'b0;
         if (resp_valid) got = 1'b1;
      end

      if (err_exp) begin
         exp_lat = 1; exp_rd = '0; exp_rdc = 0; exp_wrc = 0;
      end else if (!we) begin
         exp_lat = 3; exp_rd = ref_load(n, sg, ai); exp_rdc = 1; exp_wrc = 0;
      end else begin
         ref_store(n, ai, wd);
         exp_rd  = '0;
         exp_lat = (n == 4) ? 2 : 4;
         exp_rdc = (n == 4) ? 0 : 1;
         exp_wrc = 1;
      end

      check({tag, " resp seen"}, 32'(got), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " err"}, 32'(resp_err), 32'(err_exp));
      check({tag, " rdata"}, resp_rdata, exp_rd);
      check({tag, " busy"}, 32'(ready_low), 32'd1);
      check({tag, " reads"}, 32'(rd_cnt - rd0), 32'(exp_rdc));
      check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(exp_wrc));
      if (exp_rdc + exp_wrc > 0) check({tag, " addr"}, last_addr, a >> 2);
      if (exp_wrc > 0) check({tag, " wdata"}, last_wdata, ref_word(ai / 4));
   endtask

   initial begin
      bit seen;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      for (int i = 0; i < 64; i++) rb[i] = 8'h00;

      #3;
      check("reset ready", 32'(req_ready), 32'd1);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      check("reset resp_err", 32'(resp_err), 32'd0);
      check("reset resp_rdata", resp_rdata, 32'd0);
      check("reset addr", addr, 32'd0);
      check("reset rd strobe", 32'(mem_read_control), 32'd0);
      check("reset wr strobe", 32'(write_data_control), 32'd0);
      check("reset wdata", wdata, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int w = 0; w < 16; w++) do_req("init sw", 1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom());

      // word store then load
      do_req("sw 0x8", 1'b1, 2'd2, 1'b0, 32'h8, 32'h000877F8);
      check("sw 0x8 addr", last_addr, 32'd2);
      do_req("lw 0x8", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
      check("lw 0x8 value", resp_rdata, 32'h000877F8);

      // byte read-modify-write
      do_req("sw pre", 1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344);
      do_req("sb 0x9", 1'b1, 2'd0, 1'b0, 32'h9, 32'h000000AB);
      check("sb merged", last_wdata, 32'h1122AB44);

      do_req("lb s", 1'b0, 2'd0, 1'b1, 32'h9, 32'h0);
      check("lb signed", resp_rdata, 32'hFFFFFFAB);
      do_req("lb u", 1'b0, 2'd0, 1'b0, 32'h9, 32'h0);
      check("lb unsigned", resp_rdata, 32'h000000AB);

      do_req("sw hw", 1'b1, 2'd2, 1'b0, 32'h8, 32'h80001234);
      do_req("lh s", 1'b0, 2'd1, 1'b1, 32'hA, 32'h0);
      check("lh signed", resp_rdata, 32'hFFFF8000);

      // misaligned requests
      do_req("lw 0x6", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
      do_req("sh 0x3", 1'b1, 2'd1, 1'b0, 32'h3, 32'hDEAD);
      do_req("size3", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
      check("sh 0x3 mem unchanged", mem[0], ref_word(0));

      // reset in the middle of a read-modify-write
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h9; req_wdata = 32'h000000CD;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rmw rd strobe", 32'(mem_read_control), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid rst ready", 32'(req_ready), 32'd1);
      check("mid rst rd strobe", 32'(mem_read_control), 32'd0);
      check("mid rst wr strobe", 32'(write_data_control), 32'd0);
      check("mid rst addr", addr, 32'd0);
      check("mid rst wdata", wdata, 32'd0);
      check("mid rst resp_valid", 32'(resp_valid), 32'd0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      check("abandoned no resp", 32'(seen), 32'd0);

      // back-to-back loads
      do_req("b2b lw", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
      do_req("b2b lh", 1'b0, 2'd1, 1'b0, 32'h2, 32'h0);

      for (int k = 0; k < 150; k++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         sz = 2'($urandom_range(0, 3));
         a  = $urandom();
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         do_req("rnd", 1'($urandom()), sz, 1'($urandom()), a, $urandom());
      end

      @(negedge clk);
      check("strobe overlap", 32'(ov_cnt), 32'd0);
      for (int w = 0; w < 16; w++) check("final mem", mem[w], ref_word(w));

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the CPU's MEM stage. Accepts one byte, halfword or word request at a time from the pipeline and drives the `mem_data` word memory port (`addr`, `mem_read_control`, `write_data_control`, `wdata`, `rdata`). Sub-word stores are performed as read-modify-write, and loads are lane-extracted and sign- or zero-extended. The pipeline stalls on `req_ready`.

## Interface
- `ADDR_W`, 32, byte-address width on the pipeline side
- `DATA_W`, 32, data width; fixed at 32 (four byte lanes)
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  pipeline presents a request
- `req_ready`  out  1  unit is idle and can accept; the request is accepted on `req_valid && req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = byte, 1 = halfword, 2 = word; 3 = illegal, treated as misaligned
- `req_signed`  in  1  sign-extend the load result (ignored for word loads and for stores)
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle pulse; the request has completed
- `resp_rdata`  out  32  load result; valid only with `resp_valid`; 0 for stores and errors
- `resp_err`  out  1  misaligned or illegal request; valid only with `resp_valid`
- `addr`  out  32  word index to `mem_data`, equal to `req_addr >> 2`
- `mem_read_control`  out  1  read strobe to `mem_data`
- `write_data_control`  out  1  write strobe to `mem_data`
- `wdata`  out  32  word written to `mem_data`
- `rdata`  in  32  read word from `mem_data`; valid in the cycle after `mem_read_control` is sampled high

## Operation
- **Lane mapping:** little-endian. Byte lane k (k = `req_addr[1:0]`) occupies `[8k+7:8k]`. A halfword at offset h (h = `req_addr[1]`) occupies `[16h+15:16h]`.
- **Alignment:**
  - A halfword is misaligned when `req_addr[0]` = 1.
  - A word is misaligned when `req_addr[1:0]` ≠ 0.
  - `req_size` = 3 is always an error.
  - An error request performs no memory access.
- **Request latching:** all request fields are latched on acceptance. Later changes on the request inputs are ignored until the next acceptance.
- **States:**
  - IDLE: `req_ready` = 1.
    - On acceptance, go to ERR if misaligned.
    - Otherwise go to LD_RD for a load, ST_WR for a word store, or RMW_RD for a byte/halfword store.
  - LD_RD: drive `mem_read_control` = 1 and `addr` = word index, then go to LD_CAP.
  - LD_CAP: capture `rdata`, extract the lane, extend it, then go to RESP.
  - ST_WR: drive `write_data_control` = 1, `addr`, and `wdata` = `req_wdata`, then go to RESP.
  - RMW_RD: drive `mem_read_control` = 1, then go to RMW_MRG.
  - RMW_MRG: `wdata` = `rdata` with the target lane(s) replaced by `req_wdata[7:0]` or `req_wdata[15:0]`, then go to RMW_WR.
  - RMW_WR: drive `write_data_control` = 1 with the merged `wdata`, then go to RESP.
  - ERR: `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0, then go to IDLE.
  - RESP: `resp_valid` = 1, `resp_err` = 0, then go to IDLE.
- **Strobe rule:** `mem_read_control` and `write_data_control` are never high in the same cycle. Both are 0 outside their states.
- **Extension:**
  - Byte loads extend from bit 7; halfword loads extend from bit 15.
  - Sign extension applies when `req_signed` = 1; otherwise zero extension.
- **Outputs:** all outputs are registered or decoded from state only. No combinational path exists from the `req_*` inputs to any output.

## Timing
- **Reset values:** while `rst_n` = 0:
  - state = IDLE
  - `req_ready` = 1
  - `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0
  - `addr` = 0, `mem_read_control` = 0, `write_data_control` = 0, `wdata` = 0
- **Latency,** counted as cycles from the acceptance edge to `resp_valid` high:
  - load: 3
  - word store: 2
  - byte/halfword store: 4
  - error: 1
- **Ready timing:** `req_ready` drops the cycle after acceptance and returns high in the cycle after `resp_valid`. Back-to-back throughput is therefore latency + 1 cycles per request.
- **Store commit:** the write commits at the rising edge ending ST_WR or RMW_WR. A load issued afterwards observes the new data.
- **Reset mid-operation:** the transaction is abandoned. A write strobe that is cut off may or may not have committed. No `resp_valid` is issued for the abandoned request.
- **Address wrap:** the word index uses `req_addr[31:2]`. Upper `addr` bits follow the address directly, with no wrap logic.

## Test plan
- **Word store then load:** store `req_addr` = 0x8, `req_wdata` = 0x000877F8 (555000). Then load a word from 0x8.
  - Required: `addr` = 2 and `write_data_control` high for exactly 1 cycle.
  - Required: the load returns `resp_rdata` = 0x000877F8 with latency 3.
- **Byte RMW:** preload word 2 with 0x11223344, then store byte 0xAB at 0x9.
  - Required: one read followed by one write of 0x1122AB44, and `resp_valid` 4 cycles after acceptance.
- **Signed/unsigned byte load:** word 2 = 0x1122AB44. Load a byte at 0x9 with `req_signed` = 1, then with `req_signed` = 0.
  - Required: 0xFFFFFFAB, then 0x000000AB.
- **Halfword load:** load a halfword at 0xA with `req_signed` = 1 from 0x8000_1234.
  - Required: 0xFFFF8000.
- **Misalignment:** word load at 0x6 and halfword store at 0x3.
  - Required: `resp_err` = 1 after 1 cycle.
  - Required: `mem_read_control` and `write_data_control` stay 0 and memory is unchanged.
- **Reset and back-to-back:** assert `rst_n` = 0 during RMW_RD.
  - Required: all outputs reach their reset values immediately, with no `resp_valid`.
  - After release, issue two loads back-to-back. Required: `req_ready` deasserts and reasserts per the Timing rules, and the strobes never overlap.
